// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 WIDTH-bit mux path.
// Holds a grant while the owner keeps requesting, capped at MAX_HOLD beats.
module mux4_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       i_req,
    input  logic [WIDTH-1:0] i_din1,
    input  logic [WIDTH-1:0] i_din2,
    input  logic [WIDTH-1:0] i_din3,
    input  logic [WIDTH-1:0] i_din4,
    output logic [3:0]       o_grant,
    output logic [1:0]       o_select,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_owner;
    logic [7:0]       r_cnt;
    logic [3:0]       r_grant;
    logic [WIDTH-1:0] r_dout;
    logic             r_dv;

    logic [1:0]       w_win;
    logic             w_found;
    logic             w_rel;
    logic [WIDTH-1:0] w_din_sel;

    // Scan requests starting at the priority pointer and wrapping mod 4.
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!w_found && i_req[r_ptr + 2'(i)]) begin
                w_win   = r_ptr + 2'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        case (r_owner)
            2'd0:    w_din_sel = i_din1;
            2'd1:    w_din_sel = i_din2;
            2'd2:    w_din_sel = i_din3;
            default: w_din_sel = i_din4;
        endcase
    end

    assign w_rel = (r_state == S_GRANT) && (!i_req[r_owner] || r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|i_req) w_state_nxt = S_GRANT;
            S_GRANT: if (w_rel)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 2'd0;
            r_owner <= 2'd0;
            r_cnt   <= 8'd0;
            r_grant <= 4'd0;
            r_dout  <= '0;
            r_dv    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_dv <= 1'b0;
            if (|i_req) begin
                r_grant <= 4'b0001 << w_win;
                r_owner <= w_win;
                r_cnt   <= 8'd0;
            end
        end else begin
            // Cap release still transfers if the owner is requesting.
            r_dout <= w_din_sel;
            r_dv   <= i_req[r_owner];
            r_cnt  <= r_cnt + 8'd1;
            if (w_rel) begin
                r_grant <= 4'd0;
                r_ptr   <= r_owner + 2'd1;
            end
        end
    end

    // Owner register doubles as select so it keeps the last owner in IDLE.
    assign o_select     = r_owner;
    assign o_grant      = r_grant;
    assign o_busy       = (r_state == S_GRANT);
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dv;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter: scoreboard of expected dout beats plus
// point checks of grant/select/busy; a second instance covers MAX_HOLD=1.
module tb_mux4_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, req1;
    logic [7:0] din1, din2, din3, din4;

    logic [3:0] grant, grant1;
    logic [1:0] sel, sel1;
    logic       busy, busy1;
    logic [7:0] dout, dout1;
    logic       dv, dv1;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mux4_arbiter #(.WIDTH(8), .MAX_HOLD(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_req(req),
        .i_din1(din1), .i_din2(din2), .i_din3(din3), .i_din4(din4),
        .o_grant(grant), .o_select(sel), .o_busy(busy),
        .o_dout(dout), .o_dout_valid(dv)
    );

    mux4_arbiter #(.WIDTH(8), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_req(req1),
        .i_din1(din1), .i_din2(din2), .i_din3(din3), .i_din4(din4),
        .o_grant(grant1), .o_select(sel1), .o_busy(busy1),
        .o_dout(dout1), .o_dout_valid(dv1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Scoreboard: every valid beat must match the next expected value.
    always @(negedge clk) begin
        if (dv === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL beat_unexpected: got dout %0h want no beat", dout);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                assert (dout === e) else begin
                    bad++;
                    $error("FAIL beat_data: got %0h want %0h", dout, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] eg[5];
        logic       eb[5];
        logic       ev[5];
        logic [7:0] ed[5];

        rst_n = 1'b0; req = 4'd0; req1 = 4'd0;
        din1 = 8'd1; din2 = 8'd2; din3 = 8'd3; din4 = 8'd4;
        ticks(2);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_select", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dv", 32'(dv), 0);
        rst_n = 1'b1;

        // Round robin with everyone requesting: 4 beats per owner.
        req = 4'b1111;
        for (int o = 1; o <= 4; o++)
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(o));
        tick();
        chk("rr_grant0", 32'(grant), 32'h1);
        chk("rr_busy0", 32'(busy), 1);
        chk("rr_sel0", 32'(sel), 0);
        chk("rr_dv_lat", 32'(dv), 0);
        tick();
        chk("rr_first_beat", 32'(dv), 1);
        chk("rr_first_dout", 32'(dout), 1);
        ticks(3);
        chk("rr_cap_grant", 32'(grant), 0);
        chk("rr_cap_busy", 32'(busy), 0);
        chk("rr_cap_dv", 32'(dv), 1);
        tick();
        chk("rr_grant1", 32'(grant), 32'h2);
        chk("rr_sel1", 32'(sel), 1);
        ticks(4);
        tick();
        chk("rr_grant2", 32'(grant), 32'h4);
        ticks(4);
        tick();
        chk("rr_grant3", 32'(grant), 32'h8);
        chk("rr_sel3", 32'(sel), 3);
        ticks(4);

        // Pointer wraps 3 -> 0.
        req = 4'b1001;
        tick();
        chk("wrap_grant", 32'(grant), 32'h1);
        req = 4'd0;
        tick();
        chk("drop_busy", 32'(busy), 0);
        chk("drop_grant", 32'(grant), 0);
        chk("drop_dv", 32'(dv), 0);
        chk("drop_sel_hold", 32'(sel), 0);

        // Single requester for two beats.
        req = 4'b0100;
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd3);
        tick();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_sel", 32'(sel), 2);
        ticks(2);
        req = 4'd0;
        tick();
        chk("single_rel_grant", 32'(grant), 0);
        chk("single_rel_busy", 32'(busy), 0);
        chk("single_rel_dv", 32'(dv), 0);
        chk("single_sel_hold", 32'(sel), 2);

        // ptr is now 3, so owner 3 wins first.
        req = 4'b1111;
        tick();
        chk("ptr3_grant", 32'(grant), 32'h8);
        exp_q.push_back(8'd4);
        tick();

        // Asynchronous reset mid-grant.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_dv", 32'(dv), 0);
        chk("arst_dout", 32'(dout), 0);
        chk("arst_sel", 32'(sel), 0);
        ticks(2);
        chk("arst_dv_hold", 32'(dv), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_sel", 32'(sel), 0);

        // Early release by owner 1 while owner 2 waits.
        req = 4'd0;
        tick();
        chk("er_idle", 32'(busy), 0);
        req = 4'b0110;
        exp_q.push_back(8'd2);
        tick();
        chk("er_grant1", 32'(grant), 32'h2);
        tick();
        req = 4'b0100;
        tick();
        chk("er_rel_grant", 32'(grant), 0);
        chk("er_rel_dv", 32'(dv), 0);
        tick();
        chk("er_next_grant", 32'(grant), 32'h4);
        req = 4'd0;
        ticks(3);
        chk("sb_drained", exp_q.size(), 0);

        // MAX_HOLD=1 instance alternating between two requesters.
        eg = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h1};
        eb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ev = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ed = '{8'd0, 8'd1, 8'd0, 8'd2, 8'd0};
        req1 = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("mh1_grant%0d", k), 32'(grant1), 32'(eg[k]));
            chk($sformatf("mh1_busy%0d", k), 32'(busy1), 32'(eb[k]));
            chk($sformatf("mh1_dv%0d", k), 32'(dv1), 32'(ev[k]));
            if (ev[k]) chk($sformatf("mh1_dout%0d", k), 32'(dout1), 32'(ed[k]));
        end
        req1 = 4'd0;
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter and sequencer that shares one 4-input, WIDTH-bit mux datapath among four requesters. Each requester presents data on its `dinN` port and asserts its request; the arbiter picks one owner, drives the mux select, and forwards the owner's data as a registered, qualified output stream. Grants are held while the owner keeps requesting, capped at MAX_HOLD cycles, so no requester can starve the others. Sits between the requesting blocks and the shared 4:1 data path, and also supplies `select` to any external mux4 instance.

## Interface

- `WIDTH`, 8, data width of `din1`..`din4` and `dout`.
- `MAX_HOLD`, 4, maximum consecutive GRANT cycles per ownership; legal range 1..255.
- `clk`  in  1  single clock, all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request vector; `req[0]`..`req[3]` belong to `din1`..`din4`.
- `din1`..`din4`  in  WIDTH each  requester data.
- `grant`  out  4  one-hot grant, registered; all zero when idle.
- `select`  out  2  mux select of current/last owner: 00=din1, 01=din2, 10=din3, 11=din4.
- `busy`  out  1  high while in GRANT.
- `dout`  out  WIDTH  registered data of the owner.
- `dout_valid`  out  1  qualifies `dout`.

## Operation

- State: IDLE, GRANT. Internal: 2-bit priority pointer `ptr`, 2-bit owner, 8-bit hold counter `cnt`.
- IDLE: if `req` is nonzero at an edge, choose the first set bit scanning `ptr`, `ptr+1`, ... mod 4. Go to GRANT, set `grant` one-hot for the winner, `select` = winner index, `cnt` = 0. If `req` is zero, stay in IDLE.
- GRANT (owner k): each edge, `dout` <= `din(k+1)`, `dout_valid` <= `req[k]`. `cnt` increments.
- Release when, at an edge in GRANT, `req[k]` = 0 or `cnt` = MAX_HOLD-1. On release: go to IDLE, `grant` <= 0, `busy` <= 0, `ptr` <= k+1 mod 4 (wraps 3->0). `select` keeps value k.
- Release cycle data: if `req[k]` is still 1 at a cap-release edge, that edge also transfers (`dout_valid` <= 1). If `req[k]` = 0, `dout_valid` <= 0.
- In IDLE, `dout_valid` <= 0 and `dout` holds its last value.
- Requests from non-owners are ignored during GRANT. They are not latched; a requester must hold `req` until granted.
- Requests arriving while the arbiter is IDLE with no other requests are granted on the next edge.

## Timing

- Reset (asserted asynchronously, any state): `grant`=0, `select`=00, `busy`=0, `dout`=0, `dout_valid`=0, `ptr`=0, `cnt`=0, state IDLE. Reset mid-GRANT aborts the transfer immediately; no further `dout_valid`.
- Grant latency: `req` seen at edge N gives `grant`/`busy` high after edge N.
- First data: `dout_valid` rises after edge N+1 with `din` sampled at N+1.
- A continuously requesting owner gets exactly MAX_HOLD valid `dout` beats. It then has one IDLE cycle before any re-grant, so the bus turns around for at least 1 cycle between ownerships.
- With MAX_HOLD=1: GRANT lasts one cycle, giving one beat per ownership.
- Simultaneous requests are resolved solely by `ptr`; there is no fixed priority except after reset, when `ptr`=0 and din1 is highest.

## Test plan

- Reset: drive `rst_n`=0 mid-GRANT with `req`=4'b1111 -> all outputs zero asynchronously. After release, the first grant is 4'b0001 (`select`=00).
- Single requester: `req`=4'b0100, `din3`=3, held 2 cycles then dropped -> `grant`=0100, `select`=10, `dout`=3 with `dout_valid` for 2 beats, then IDLE and `ptr`=3.
- Round-robin fairness: `req`=4'b1111 constant, `din1..4`=1,2,3,4, MAX_HOLD=4 -> owners 0,1,2,3,0 in order. Each gives 4 valid beats of its value, separated by 1 idle cycle.
- Wrap-around: after owner 3 releases with `req`=4'b1001 -> next grant is 0001 (`ptr` wrapped to 0), not 1000.
- Early release: owner 1 drops `req[1]` after 1 beat while `req[2]` is high -> exactly 1 `dout_valid` beat of `din2`, IDLE one cycle, then `grant`=0100.
- MAX_HOLD=1 with `req`=4'b0011 -> alternating grants 0001/0010, one beat each, `busy` toggling 1,0,1,0.
